// File: rtl/edge_detect_stream.sv
// rtl/edge_detect_stream.sv - RGB to Sobel edge stream with line buffers, end-of-frame flush and frame-done pulse
// Output for pixel k-W-1 is produced on the read of pixel k; the last W+1 outputs drain in FLUSH.
module edge_detect_stream #(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 720,
    parameter int IMAGE_HEIGHT = 540
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] threshold,
    input  logic                  in_empty,
    input  logic [DATA_WIDTH-1:0] red_in,
    input  logic [DATA_WIDTH-1:0] green_in,
    input  logic [DATA_WIDTH-1:0] blue_in,
    output logic                  in_rd,
    input  logic                  out_full,
    output logic                  out_wr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;
    typedef logic signed [DW+3:0] sw_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, ocol_q;
    logic [RW-1:0]   row_q, orow_q;
    logic            cfg_mode_q;
    logic [DW-1:0]   cfg_thr_q;
    logic            busy_q;
    logic            first_read;

    logic [DW+1:0]   gray_sum;
    logic [DW-1:0]   gray;
    logic [DW-1:0]   lb1 [IMAGE_WIDTH];
    logic [DW-1:0]   lb2 [IMAGE_WIDTH];
    logic [DW-1:0]   tap1, tap2;
    logic [DW-1:0]   t0, t1, m0, m1, b0, b1;

    sw_t             gx, gy;
    logic [DW+3:0]   gx_abs, gy_abs, mag_sum;
    logic [DW-1:0]   mag, pix;
    logic            interior;

    function automatic sw_t x1(input logic [DW-1:0] v);
        return sw_t'({4'b0000, v});
    endfunction

    function automatic sw_t x2(input logic [DW-1:0] v);
        return sw_t'({3'b000, v, 1'b0});
    endfunction

    assign gray_sum = {2'b00, red_in} + {1'b0, green_in, 1'b0} + {2'b00, blue_in};
    assign gray     = DW'(gray_sum >> 2);
    assign tap1     = lb1[col_q];
    assign tap2     = lb2[col_q];

    // Line buffers and window taps carry no reset; border masking hides stale contents.
    always_ff @(posedge clk) begin
        if (in_rd) begin
            lb1[col_q] <= gray;
            lb2[col_q] <= tap1;
            t1 <= tap2;
            t0 <= t1;
            m1 <= tap1;
            m0 <= m1;
            b1 <= gray;
            b0 <= b1;
        end
    end

    // Window: row 0 = t0,t1,tap2; row 1 = m0,m1,tap1; row 2 = b0,b1,gray.
    assign gx = (x1(tap2) + x2(tap1) + x1(gray)) - (x1(t0) + x2(m0) + x1(b0));
    assign gy = (x1(b0) + x2(b1) + x1(gray)) - (x1(t0) + x2(t1) + x1(tap2));

    assign gx_abs   = gx[DW+3] ? -gx : gx;
    assign gy_abs   = gy[DW+3] ? -gy : gy;
    assign mag_sum  = gx_abs + gy_abs;
    assign mag      = (|mag_sum[DW+3:DW]) ? {DW{1'b1}} : mag_sum[DW-1:0];
    assign pix      = cfg_mode_q ? ((mag >= cfg_thr_q) ? {DW{1'b1}} : {DW{1'b0}}) : mag;
    assign interior = (orow_q != '0) && (orow_q != ROW_LAST) && (ocol_q != '0) && (ocol_q != COL_LAST);
    assign data_out = (out_wr && interior) ? pix : '0;

    assign first_read = in_rd && (state_q == S_FILL) && (row_q == '0) && (col_q == '0);
    assign busy       = busy_q;

    always_comb begin
        state_d    = state_q;
        in_rd      = 1'b0;
        out_wr     = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_FILL: begin
                in_rd = !in_empty;
                if (in_rd && (row_q == ROW_ONE) && (col_q == '0)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                in_rd  = !in_empty && !out_full;
                out_wr = in_rd;
                if (in_rd && (row_q == ROW_LAST) && (col_q == COL_LAST)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                out_wr = !out_full;
                if (out_wr && (orow_q == ROW_LAST) && (ocol_q == COL_LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_FILL;
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FILL;
            col_q      <= '0;
            row_q      <= '0;
            ocol_q     <= '0;
            orow_q     <= '0;
            cfg_mode_q <= 1'b0;
            cfg_thr_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_rd) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            if (out_wr) begin
                if (ocol_q == COL_LAST) begin
                    ocol_q <= '0;
                    orow_q <= (orow_q == ROW_LAST) ? '0 : orow_q + 1'b1;
                end else begin
                    ocol_q <= ocol_q + 1'b1;
                end
            end
            if (first_read) begin
                cfg_mode_q <= mode;
                cfg_thr_q  <= threshold;
            end
            // busy drops together with entry into DONE so it reads 0 during the frame_done pulse.
            if (state_q == S_FLUSH && state_d == S_DONE) begin
                busy_q <= 1'b0;
            end else if (first_read) begin
                busy_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_edge_detect_stream.sv
// tb/tb_edge_detect_stream.sv - self-checking bench for edge_detect_stream (4x4 frames, 8-bit)
module tb_edge_detect_stream;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mode = 1'b0;
    logic [DW-1:0] threshold = '0;
    logic          in_empty = 1'b1;
    logic [DW-1:0] red_in = '0, green_in = '0, blue_in = '0;
    logic          in_rd;
    logic          out_full = 1'b0;
    logic          out_wr;
    logic [DW-1:0] data_out;
    logic          frame_done;
    logic          busy;

    always #5 clk = ~clk;

    edge_detect_stream #(.DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .mode(mode), .threshold(threshold),
        .in_empty(in_empty), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .in_rd(in_rd), .out_full(out_full), .out_wr(out_wr), .data_out(data_out),
        .frame_done(frame_done), .busy(busy)
    );

    typedef struct {
        int        pat;
        bit        md;
        int        thr;
        int        stall_at;
        logic [7:0] exp [N];
    } vec_t;

    vec_t        vecs [6];
    logic [23:0] pix_q [$];
    logic [23:0] fb [N];
    logic [7:0]  cap_q [$];
    int          exp_q [$];
    bit          cfg_md_q [$];
    int          cfg_thr_q [$];
    int          reads, done_cnt, bubble_pct, full_pct, stall_at, stall_left;
    bit          stall_now;
    int          checks = 0;
    int          passes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic gen_frame(input int pat);
        for (int i = 0; i < N; i++) begin
            int c, r8, g8, b8;
            c = i % W;
            case (pat)
                0:       begin r8 = 100; g8 = 100; b8 = 100; end
                1:       begin r8 = (c >= 2) ? 255 : 0; g8 = r8; b8 = r8; end
                2:       begin r8 = 10 * c; g8 = r8; b8 = r8; end
                3:       begin r8 = int'($urandom_range(0, 63)); g8 = int'($urandom_range(0, 63)); b8 = int'($urandom_range(0, 63)); end
                default: begin r8 = int'($urandom_range(0, 255)); g8 = int'($urandom_range(0, 255)); b8 = int'($urandom_range(0, 255)); end
            endcase
            fb[i] = {8'(r8), 8'(g8), 8'(b8)};
            pix_q.push_back(fb[i]);
        end
    endtask

    // Reference: gray image, then Sobel at each interior coordinate with integer arithmetic.
    task automatic model_frame(input bit md, input int thr);
        int g [N];
        for (int i = 0; i < N; i++)
            g[i] = (int'(fb[i][23:16]) + 2 * int'(fb[i][15:8]) + int'(fb[i][7:0])) / 4;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int gx, gy, mag, e;
                e = 0;
                if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
                    gx = (g[(r-1)*W+c+1] + 2*g[r*W+c+1] + g[(r+1)*W+c+1])
                       - (g[(r-1)*W+c-1] + 2*g[r*W+c-1] + g[(r+1)*W+c-1]);
                    gy = (g[(r+1)*W+c-1] + 2*g[(r+1)*W+c] + g[(r+1)*W+c+1])
                       - (g[(r-1)*W+c-1] + 2*g[(r-1)*W+c] + g[(r-1)*W+c+1]);
                    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                    if (mag > 255) mag = 255;
                    e = md ? ((mag >= thr) ? 255 : 0) : mag;
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive_inputs();
        int fr;
        in_empty = (pix_q.size() == 0) || (int'($urandom_range(0, 99)) < bubble_pct);
        if (pix_q.size() > 0) {red_in, green_in, blue_in} = pix_q[0];
        else {red_in, green_in, blue_in} = 24'h0;
        stall_now = 1'b0;
        if (stall_at >= 0 && cap_q.size() == stall_at && stall_left > 0) begin
            out_full = 1'b1;
            stall_left--;
            stall_now = 1'b1;
        end else begin
            out_full = (int'($urandom_range(0, 99)) < full_pct);
        end
        fr = reads / N;
        if (reads % N == 0 && fr < cfg_md_q.size()) begin
            mode = cfg_md_q[fr];
            threshold = 8'(cfg_thr_q[fr]);
        end else begin
            mode = 1'($urandom);
            threshold = 8'($urandom);
        end
    endtask

    task automatic start_test();
        cap_q.delete(); exp_q.delete(); pix_q.delete();
        cfg_md_q.delete(); cfg_thr_q.delete();
        reads = 0; done_cnt = 0; stall_at = -1; stall_left = 0;
        bubble_pct = 0; full_pct = 0;
    endtask

    task automatic run_frames(input int nframes, input int max_reads, input int budget);
        int cyc, last_wr;
        logic s_rd, s_wr, s_fd, s_full, s_empty, s_busy, s_stall;
        logic [7:0] s_d;
        cyc = 0;
        last_wr = -10;
        @(posedge clk); #1;
        drive_inputs();
        while (cyc < budget) begin
            @(negedge clk);
            s_rd = in_rd; s_wr = out_wr; s_d = data_out; s_fd = frame_done;
            s_full = out_full; s_empty = in_empty; s_busy = busy; s_stall = stall_now;
            if (s_empty) check("rd_while_empty", int'(s_rd), 0);
            if (s_full) check("wr_while_full", int'(s_wr), 0);
            if (s_stall) check("rd_during_stall", int'(s_rd), 0);
            if (s_wr) begin
                cap_q.push_back(s_d);
                last_wr = cyc;
                if (cap_q.size() % N == 1) check("busy_at_first_write", int'(s_busy), 1);
            end
            if (s_fd) begin
                done_cnt++;
                check("done_after_last_write", cyc - last_wr, 1);
                check("writes_at_done", cap_q.size(), N * done_cnt);
                check("busy_in_done", int'(s_busy), 0);
            end
            cyc++;
            if (done_cnt >= nframes) break;
            @(posedge clk); #1;
            if (s_rd) begin
                void'(pix_q.pop_front());
                reads++;
            end
            drive_inputs();
            if (reads >= max_reads) break;
        end
        check("run_complete", int'(done_cnt >= nframes || reads >= max_reads), 1);
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, "_write_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_pix%0d", tag, i), int'(cap_q[i]), exp_q[i]);
    endtask

    task automatic post_frame_idle(input string tag);
        @(negedge clk);
        check({tag, "_busy_after_done"}, int'(busy), 0);
        check({tag, "_single_done_pulse"}, int'(frame_done), 0);
    endtask

    task automatic do_reset();
        in_empty = 1'b1;
        out_full = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rst_in_rd", int'(in_rd), 0);
        check("rst_out_wr", int'(out_wr), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_data_out", int'(data_out), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_rd", int'(in_rd), 0);
            check("idle_out_wr", int'(out_wr), 0);
            check("idle_busy", int'(busy), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{pat: 0, md: 0, thr: 0,  stall_at: -1, exp: '{default: 8'd0}};
        vecs[1] = '{pat: 1, md: 0, thr: 0,  stall_at: -1,
                    exp: '{0,0,0,0, 0,255,255,0, 0,255,255,0, 0,0,0,0}};
        vecs[2] = '{pat: 2, md: 1, thr: 80, stall_at: -1,
                    exp: '{0,0,0,0, 0,255,255,0, 0,255,255,0, 0,0,0,0}};
        vecs[3] = '{pat: 2, md: 1, thr: 81, stall_at: -1, exp: '{default: 8'd0}};
        vecs[4] = '{pat: 2, md: 0, thr: 0,  stall_at: -1,
                    exp: '{0,0,0,0, 0,80,80,0, 0,80,80,0, 0,0,0,0}};
        vecs[5] = '{pat: 1, md: 0, thr: 0,  stall_at: 7,
                    exp: '{0,0,0,0, 0,255,255,0, 0,255,255,0, 0,0,0,0}};

        start_test();
        repeat (2) @(negedge clk);
        do_reset();

        for (int v = 0; v < 6; v++) begin
            start_test();
            gen_frame(vecs[v].pat);
            cfg_md_q.push_back(vecs[v].md);
            cfg_thr_q.push_back(vecs[v].thr);
            for (int i = 0; i < N; i++) exp_q.push_back(int'(vecs[v].exp[i]));
            stall_at = vecs[v].stall_at;
            stall_left = (stall_at >= 0) ? 5 : 0;
            run_frames(1, 1 << 30, 200);
            compare_outputs($sformatf("vec%0d", v));
            check($sformatf("vec%0d_done_count", v), done_cnt, 1);
            if (stall_at >= 0) check("stall_fully_applied", stall_left, 0);
            post_frame_idle($sformatf("vec%0d", v));
        end

        // Abort mid-frame, then a clean frame must follow.
        start_test();
        gen_frame(1);
        cfg_md_q.push_back(1'b0);
        cfg_thr_q.push_back(0);
        run_frames(1, 7, 200);
        in_empty = 1'b1;
        check("partial_no_done", done_cnt, 0);
        do_reset();
        start_test();
        gen_frame(1);
        cfg_md_q.push_back(1'b0);
        cfg_thr_q.push_back(0);
        for (int i = 0; i < N; i++) exp_q.push_back(int'(vecs[1].exp[i]));
        run_frames(1, 1 << 30, 200);
        compare_outputs("after_abort");
        check("after_abort_done_count", done_cnt, 1);
        post_frame_idle("after_abort");

        // Back-to-back random frames with input bubbles and output back-pressure.
        start_test();
        bubble_pct = 20;
        full_pct = 20;
        for (int f = 0; f < 6; f++) begin
            bit md;
            int thr;
            md = 1'($urandom_range(0, 1));
            thr = int'($urandom_range(0, 255));
            gen_frame(3 + (f % 2));
            cfg_md_q.push_back(md);
            cfg_thr_q.push_back(thr);
            model_frame(md, thr);
        end
        run_frames(6, 1 << 30, 3000);
        compare_outputs("random");
        check("random_done_count", done_cnt, 6);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
